// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: in-order fetch into a small buffer, with branch/jump/jar redirect.
// Optional retirement/redirect counters are added when IFU_PERF_CNT_EN is defined.
module ifu_prefetch #(
    parameter int unsigned     PC_W     = 30,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            start,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     instruction,
    output logic [PC_W-1:0] inst_pc,
    output logic [PC_W-1:0] delayslot2,
    input  logic            branch,
    input  logic            zero,
    input  logic            jump,
    input  logic            jar,
    input  logic [PC_W-1:0] newPC
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     flush_count
`endif
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    // Sized generously so back-to-back redirects against slow memory cannot wrap it.
    localparam int unsigned DISC_W = 16;

    typedef struct packed {
        logic [31:0]     word;
        logic [PC_W-1:0] pc;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PC_W-1:0]   fetch_pc, fetch_pc_n;
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
    logic [CNT_W-1:0]  count, count_n, count_left, outst, outst_n;
    logic [DISC_W-1:0] disc, disc_n;
    logic              req_n, valid_n;
    logic [31:0]       instr_n;
    logic [PC_W-1:0]   pc_n, ds_n;
    logic              grant, retire, taken, redirect, write;
    logic [PC_W-1:0]   p1, br_tgt, jmp_tgt, target;
    entry_t            wr_entry, head;

    assign imem_addr = 32'({fetch_pc, 2'b00});

    // Next-state: fetch pointer, buffer bookkeeping, redirect and head register.
    always_comb begin
        grant    = imem_req & imem_gnt;
        retire   = inst_valid & inst_ready;
        taken    = branch & (zero ^ instruction[26]);
        redirect = retire & (jar | jump | taken);
        p1       = inst_pc + PC_W'(1);
        br_tgt   = p1 + PC_W'({{16{instruction[15]}}, instruction[15:0]});
        jmp_tgt  = p1 + PC_W'({{6{instruction[25]}}, instruction[25:0]});
        target   = jar ? newPC : (jump ? jmp_tgt : br_tgt);
        write    = imem_rvalid & (disc == '0) & ~redirect;

        // Responses return in order, so the oldest live request is fetch_pc - outst.
        wr_entry.word = imem_rdata;
        wr_entry.pc   = fetch_pc - PC_W'(outst);

        fetch_pc_n = grant ? fetch_pc + PC_W'(1) : fetch_pc;
        wr_ptr_n   = write ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_ptr_n   = retire ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_left = count - CNT_W'(retire);
        count_n    = count_left + CNT_W'(write);
        outst_n    = outst + CNT_W'(grant) - CNT_W'(write);
        disc_n     = (imem_rvalid && (disc != '0)) ? disc - DISC_W'(1) : disc;
        head       = (count_left == '0) ? wr_entry : mem[rd_ptr_n];

        if (redirect) begin
            fetch_pc_n = target;
            wr_ptr_n   = wr_ptr;
            rd_ptr_n   = wr_ptr;
            count_n    = '0;
            outst_n    = '0;
            disc_n     = disc + DISC_W'(outst) + DISC_W'(grant) - DISC_W'(imem_rvalid);
        end

        valid_n = (count_n != '0);
        instr_n = valid_n ? head.word : instruction;
        pc_n    = valid_n ? head.pc : inst_pc;
        ds_n    = pc_n + PC_W'(2);
        req_n   = ((CNT_W+1)'(count_n) + (CNT_W+1)'(outst_n)) < (CNT_W+1)'(DEPTH);
    end

    always_ff @(posedge clock or negedge start) begin
        if (!start) begin
            fetch_pc    <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outst       <= '0;
            disc        <= '0;
            imem_req    <= 1'b0;
            inst_valid  <= 1'b0;
            instruction <= '0;
            inst_pc     <= RESET_PC;
            delayslot2  <= RESET_PC + PC_W'(2);
        end else begin
            fetch_pc    <= fetch_pc_n;
            wr_ptr      <= wr_ptr_n;
            rd_ptr      <= rd_ptr_n;
            count       <= count_n;
            outst       <= outst_n;
            disc        <= disc_n;
            imem_req    <= req_n;
            inst_valid  <= valid_n;
            instruction <= instr_n;
            inst_pc     <= pc_n;
            delayslot2  <= ds_n;
        end
    end

    // Buffer storage carries no reset; occupancy alone qualifies its contents.
    always_ff @(posedge clock) begin
        if (write) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clock or negedge start) begin
        if (!start) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (retire) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (redirect) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: in-order memory model, rule-driven consumer, hand-computed expectations.
module tb_ifu_prefetch;
    localparam int unsigned PC_W = 30;

    logic            clock, start;
    logic            imem_req, imem_gnt, imem_rvalid;
    logic [31:0]     imem_addr, imem_rdata;
    logic            inst_valid, inst_ready;
    logic [31:0]     instruction;
    logic [PC_W-1:0] inst_pc, delayslot2, newPC;
    logic            branch, zero, jump, jar;
`ifdef IFU_PERF_CNT_EN
    logic [31:0]     fetch_count, flush_count;
`endif

    ifu_prefetch #(.PC_W(PC_W), .DEPTH(4), .RESET_PC('0)) dut (
        .clock(clock), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction),
        .inst_pc(inst_pc), .delayslot2(delayslot2),
        .branch(branch), .zero(zero), .jump(jump), .jar(jar), .newPC(newPC)
`ifdef IFU_PERF_CNT_EN
        , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
    );

    int checks = 0;
    int failures = 0;
    int lat = 1;
    int ncyc = 0;
    bit force_jar = 0;

    logic [31:0]     q_addr[$];
    int              q_due[$];
    logic [31:0]     grant_log[$];
    logic [PC_W-1:0] ret_pc[$];
    logic [PC_W-1:0] ret_ds[$];
    logic [31:0]     ret_ins[$];

    logic [PC_W-1:0] ov_pc[8];
    logic [31:0]     ov_ins[8];
    int              n_ov = 0;

    logic [PC_W-1:0] r_pc[8];
    logic [PC_W-1:0] r_new[8];
    bit              r_br[8], r_zero[8], r_jump[8], r_jar[8], r_used[8];
    int              n_rules = 0;

    bit              redir_prev = 0;
    bit              post_seen = 0;
    logic            post_valid, post_req;
    logic [31:0]     post_addr;
    int              redir_inflight = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] prog(input logic [PC_W-1:0] pc);
        logic [31:0] w = {2'b11, pc};
        for (int i = 0; i < n_ov; i++) begin
            if (ov_pc[i] == pc) w = ov_ins[i];
        end
        return w;
    endfunction

    task automatic add_ov(input logic [PC_W-1:0] pc, input logic [31:0] ins);
        ov_pc[n_ov] = pc;
        ov_ins[n_ov] = ins;
        n_ov++;
    endtask

    task automatic add_rule(input logic [PC_W-1:0] pc, input bit br, input bit z, input bit jmp,
                            input bit jr, input logic [PC_W-1:0] np);
        r_pc[n_rules] = pc;  r_br[n_rules] = br;  r_zero[n_rules] = z;
        r_jump[n_rules] = jmp; r_jar[n_rules] = jr; r_new[n_rules] = np;
        r_used[n_rules] = 0;
        n_rules++;
    endtask

    // Memory model, consumer flag driver and retirement monitor, all mid-cycle.
    initial begin
        logic [PC_W-1:0] rpc;
        bit hit;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        branch = 0; zero = 0; jump = 0; jar = 0; newPC = '0;
        forever begin
            @(negedge clock);
            #2;
            ncyc++;
            if (!start) begin
                q_addr.delete();
                q_due.delete();
                imem_gnt = 0; imem_rvalid = 0;
                branch = 0; zero = 0; jump = 0; jar = 0;
                redir_prev = 0;
            end else begin
                if (redir_prev) begin
                    post_valid = inst_valid;
                    post_req   = imem_req;
                    post_addr  = imem_addr;
                    post_seen  = 1;
                    redir_prev = 0;
                end
                imem_rvalid = 0;
                if (q_due.size() > 0 && q_due[0] <= ncyc) begin
                    rpc = q_addr[0][31:2];
                    imem_rvalid = 1;
                    imem_rdata = prog(rpc);
                    void'(q_addr.pop_front());
                    void'(q_due.pop_front());
                end
                imem_gnt = 1;
                if (imem_req) begin
                    q_addr.push_back(imem_addr);
                    q_due.push_back(ncyc + lat);
                    grant_log.push_back(imem_addr);
                end
                branch = 0; zero = 0; jump = 0;
                jar = force_jar;
                newPC = force_jar ? 30'h200 : '0;
                if (inst_valid && inst_ready) begin
                    hit = 0;
                    for (int i = 0; i < n_rules; i++) begin
                        if (!hit && !r_used[i] && r_pc[i] == inst_pc) begin
                            branch = r_br[i]; zero = r_zero[i]; jump = r_jump[i];
                            jar = r_jar[i]; newPC = r_new[i];
                            r_used[i] = 1;
                            hit = 1;
                            redir_prev = 1;
                            redir_inflight = q_due.size();
                        end
                    end
                    ret_pc.push_back(inst_pc);
                    ret_ds.push_back(delayslot2);
                    ret_ins.push_back(instruction);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req"}, imem_req, 0);
        check({pfx, "_addr"}, imem_addr, 0);
        check({pfx, "_valid"}, inst_valid, 0);
        check({pfx, "_instr"}, instruction, 0);
        check({pfx, "_pc"}, inst_pc, 0);
        check({pfx, "_ds2"}, delayslot2, 2);
`ifdef IFU_PERF_CNT_EN
        check({pfx, "_fcnt"}, fetch_count, 0);
        check({pfx, "_flcnt"}, flush_count, 0);
`endif
    endtask

    task automatic do_reset();
        start = 0;
        inst_ready = 0;
        force_jar = 0;
        repeat (2) @(negedge clock);
        grant_log.delete(); ret_pc.delete(); ret_ds.delete(); ret_ins.delete();
        n_ov = 0; n_rules = 0; post_seen = 0;
        check_reset_outputs("rst");
        start = 1;
        @(negedge clock);
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 0);
    endtask

    task automatic wait_retired(input int n, input string tag);
        int budget = 300;
        while (ret_pc.size() < n && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (ret_pc.size() < n) check(tag, ret_pc.size(), n);
    endtask

    initial begin
        logic [PC_W-1:0] exp_c[9];
        logic [PC_W-1:0] exp_d[13];
        start = 0;
        inst_ready = 0;

        // Streaming: latency 1, consumer always ready.
        lat = 1;
        do_reset();
        inst_ready = 1;
        wait_retired(6, "a_timeout");
        for (int i = 0; i < 6; i++) begin
            check($sformatf("a_pc%0d", i), ret_pc[i], i);
            check($sformatf("a_ins%0d", i), ret_ins[i], {2'b11, 30'(i)});
            check($sformatf("a_ds%0d", i), ret_ds[i], i + 2);
        end
        for (int i = 0; i < 3; i++) check($sformatf("a_addr%0d", i), grant_log[i], 4 * i);

        // Stalled consumer fills the buffer; jar while not retiring must be ignored.
        do_reset();
        force_jar = 1;
        repeat (12) @(negedge clock);
        check("b_grants", grant_log.size(), 4);
        check("b_req", imem_req, 0);
        check("b_valid", inst_valid, 1);
        check("b_pc", inst_pc, 0);
        check("b_instr", instruction, 32'hC000_0000);
        force_jar = 0;
        inst_ready = 1;
        wait_retired(3, "b_timeout");
        for (int i = 0; i < 3; i++) check($sformatf("b_pc%0d", i), ret_pc[i], i);

        // beq at pc 5, imm -2, zero=1: target = 6 - 2 = 4; in-flight fetches of 6,7 dropped.
        lat = 2;
        do_reset();
        add_ov(30'd5, 32'h1000_FFFE);
        add_rule(30'd5, 1, 1, 0, 0, '0);
        inst_ready = 1;
        wait_retired(9, "c_timeout");
        exp_c = '{30'd0, 30'd1, 30'd2, 30'd3, 30'd4, 30'd5, 30'd4, 30'd5, 30'd6};
        for (int i = 0; i < 9; i++) check($sformatf("c_pc%0d", i), ret_pc[i], exp_c[i]);
        check("c_post_seen", post_seen, 1);
        check("c_post_valid", post_valid, 0);
        check("c_post_req", post_req, 1);
        check("c_post_addr", post_addr, 32'h10);
        check("c_inflight_ge2", redir_inflight >= 2, 1);

        // jar beats jump; bne with zero=1 falls through; plain jump; jar to top of PC space wraps.
        lat = 1;
        do_reset();
        add_ov(30'd3, 32'h0800_0010);
        add_rule(30'd3, 0, 0, 1, 1, 30'h100);
        add_ov(30'h102, 32'h1400_0008);
        add_rule(30'h102, 1, 1, 0, 0, '0);
        add_ov(30'h104, 32'h0800_0010);
        add_rule(30'h104, 0, 0, 1, 0, '0);
        add_rule(30'h115, 0, 0, 0, 1, 30'h3FFF_FFFF);
        inst_ready = 1;
        wait_retired(13, "d_timeout");
        inst_ready = 0;
        exp_d = '{30'd0, 30'd1, 30'd2, 30'd3, 30'h100, 30'h101, 30'h102, 30'h103,
                  30'h104, 30'h115, 30'h3FFF_FFFF, 30'd0, 30'd1};
        for (int i = 0; i < 13; i++) begin
            check($sformatf("d_pc%0d", i), ret_pc[i], exp_d[i]);
            check($sformatf("d_ins%0d", i), ret_ins[i], prog(exp_d[i]));
        end
        check("d_ds_wrap", ret_ds[10], 1);
        repeat (2) @(negedge clock);
`ifdef IFU_PERF_CNT_EN
        check("d_fetch_count", fetch_count, 13);
        check("d_flush_count", flush_count, 3);
`endif

        // Asynchronous reset with buffer occupied and requests outstanding.
        lat = 3;
        do_reset();
        repeat (4) @(negedge clock);
        check("e_pre_valid", inst_valid, 1);
        check("e_pre_req", imem_req, 0);
        #3 start = 0;
        #1 check_reset_outputs("e_async");
        do_reset();
        lat = 1;
        inst_ready = 1;
        wait_retired(3, "e_timeout");
        check("e_addr0", grant_log[0], 0);
        for (int i = 0; i < 3; i++) check($sformatf("e_pc%0d", i), ret_pc[i], i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
